bcd_modn_counter: RTL and testbench

BCD_MODN_COUNTER -- requirements
Module: bcd_modn_counter

---
 rtl/bcd_modn_counter_if.sv | 53 +++++
 rtl/bcd_modn_counter.sv | 198 +++++++++++++++++++
 tb/tb_bcd_modn_counter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_modn_counter_if.sv
// rtl/bcd_modn_counter_if.sv - Signal bundle for the BCD modulo-N start/pause counter
//
// Purpose : groups the push-button, count-control and display signals of
//           bcd_modn_counter so that they travel as one port.
// Signals :
//   key            start/pause button, active-low, asynchronous to clk
//   up             count direction, 1 = up, 0 = down
//   load           one-cycle synchronous load strobe, active-high
//   load_val[7:0]  BCD value to load, {tens, units}
//   run            1 = counting, 0 = paused
//   cnt[7:0]       current BCD count, {tens, units}
//   carry          one-cycle pulse on wrap in either direction
//   segment_led_1  tens digit, {SEG, DP, G, F, E, D, C, B, A}
//   segment_led_2  units digit, same bit order
// Modports:
//   master - drives the controls and observes the outputs
//   slave  - the counter itself

interface bcd_modn_counter_if;
    logic       key;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic       run;
    logic [7:0] cnt;
    logic       carry;
    logic [8:0] segment_led_1;
    logic [8:0] segment_led_2;

    modport master (
        output key,
        output up,
        output load,
        output load_val,
        input  run,
        input  cnt,
        input  carry,
        input  segment_led_1,
        input  segment_led_2
    );

    modport slave (
        input  key,
        input  up,
        input  load,
        input  load_val,
        output run,
        output cnt,
        output carry,
        output segment_led_1,
        output segment_led_2
    );
endinterface

// File: rtl/bcd_modn_counter.sv
// rtl/bcd_modn_counter.sv - Two-digit BCD modulo-N up/down counter with debounced start/pause key
//
// Purpose : a prescaler divides clk down to a count tick; on each tick the
//           two-digit BCD count steps up or down modulo MOD_N while running.
//           A debounced push button toggles run; a load strobe presets the
//           count. Both digits are decoded to active-high seven-segment codes.
// Parameters:
//   DIV_N  clk cycles per count tick (>= 2)
//   MOD_N  count modulus, 2..100; sequence 0..MOD_N-1
//   DEB_N  cycles the key must be stable before it is accepted (>= 1)
// Ports:
//   clk    system clock, all state on its rising edge
//   rst    synchronous reset, active-low
//   bus    bcd_modn_counter_if.slave (key, up, load, load_val in;
//          run, cnt, carry, segment_led_1, segment_led_2 out)

module bcd_modn_counter #(
    parameter int DIV_N = 12_000_000,
    parameter int MOD_N = 60,
    parameter int DEB_N = 240_000
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_modn_counter_if.slave     bus
);

    localparam int PRE_W = $clog2(DIV_N);
    localparam int DEB_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_N - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);

    // Highest count value, MOD_N-1, in BCD.
    localparam logic [3:0] MAX_TENS  = 4'((MOD_N - 1) / 10);
    localparam logic [3:0] MAX_UNITS = 4'((MOD_N - 1) % 10);
    localparam logic [7:0] MAX_BCD   = {MAX_TENS, MAX_UNITS};

    // ------------------------------------------------------------------
    // Key synchroniser and debouncer
    // ------------------------------------------------------------------
    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_deb_diff;
    logic             w_deb_flip;
    logic             w_key_fall;

    // r_deb_cnt counts consecutive cycles in which the synchronised key
    // disagrees with the accepted level; the level flips on the DEB_N-th.
    assign w_deb_diff = (r_sync2 != r_deb);
    assign w_deb_flip = w_deb_diff && (r_deb_cnt == DEB_LAST);
    // A flip away from released (1) is the accepted press.
    assign w_key_fall = w_deb_flip && r_deb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= bus.key;
            r_sync2 <= r_sync1;
            if (!w_deb_diff || w_deb_flip) begin
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
            if (w_deb_flip) begin
                r_deb <= r_sync2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Start/pause state
    // ------------------------------------------------------------------
    logic r_run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else if (w_key_fall) begin
            r_run <= ~r_run;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: free-running, unaffected by run and load
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] r_pre;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // BCD count
    // ------------------------------------------------------------------
    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic       r_carry;
    logic [7:0] w_cnt;
    logic       w_load_ok;
    logic [7:0] w_load_bcd;
    logic [7:0] w_step_bcd;
    logic       w_step_wrap;

    assign w_cnt = {r_tens, r_units};

    // With both digits legal, BCD ordering matches plain binary ordering,
    // so the range check can compare the packed byte directly.
    assign w_load_ok  = (bus.load_val[7:4] <= 4'd9) &&
                        (bus.load_val[3:0] <= 4'd9) &&
                        (bus.load_val <= MAX_BCD);
    assign w_load_bcd = w_load_ok ? bus.load_val : 8'h00;

    always_comb begin
        w_step_bcd  = w_cnt;
        w_step_wrap = 1'b0;
        if (bus.up) begin
            if (w_cnt == MAX_BCD) begin
                w_step_bcd  = 8'h00;
                w_step_wrap = 1'b1;
            end else if (r_units == 4'd9) begin
                w_step_bcd = {r_tens + 4'd1, 4'd0};
            end else begin
                w_step_bcd = {r_tens, r_units + 4'd1};
            end
        end else begin
            if (w_cnt == 8'h00) begin
                w_step_bcd  = MAX_BCD;
                w_step_wrap = 1'b1;
            end else if (r_units == 4'd0) begin
                w_step_bcd = {r_tens - 4'd1, 4'd9};
            end else begin
                w_step_bcd = {r_tens, r_units - 4'd1};
            end
        end
    end

    // Load wins over a coinciding tick and never produces a carry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_carry <= 1'b0;
        end else if (bus.load) begin
            r_tens  <= w_load_bcd[7:4];
            r_units <= w_load_bcd[3:0];
            r_carry <= 1'b0;
        end else if (w_tick && r_run) begin
            r_tens  <= w_step_bcd[7:4];
            r_units <= w_step_bcd[3:0];
            r_carry <= w_step_wrap;
        end else begin
            r_carry <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Seven-segment decode, A..G active-high, SEG and DP held at 0
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign bus.run           = r_run;
    assign bus.cnt           = w_cnt;
    assign bus.carry         = r_carry;
    assign bus.segment_led_1 = {2'b00, seg_decode(r_tens)};
    assign bus.segment_led_2 = {2'b00, seg_decode(r_units)};

endmodule

// File: tb/tb_bcd_modn_counter.sv
// tb/tb_bcd_modn_counter.sv - Scoreboard bench for bcd_modn_counter at MOD_N 60, 24 and 100
//
// Purpose : three counters (MOD_N = 60, 24, 100; DIV_N = 4, DEB_N = 3) share
//           clk, rst and stimulus. A reference model steps once per clock and
//           queues the expected outputs; a monitor pops and compares them on
//           the falling edge.

module tb_bcd_modn_counter;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       key  = 1'b1;
    logic       up   = 1'b1;
    logic       load = 1'b0;
    logic [7:0] lval = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_modn_counter_if if60 ();
    bcd_modn_counter_if if24 ();
    bcd_modn_counter_if if100 ();

    assign if60.key       = key;
    assign if60.up        = up;
    assign if60.load      = load;
    assign if60.load_val  = lval;
    assign if24.key       = key;
    assign if24.up        = up;
    assign if24.load      = load;
    assign if24.load_val  = lval;
    assign if100.key      = key;
    assign if100.up       = up;
    assign if100.load     = load;
    assign if100.load_val = lval;

    bcd_modn_counter #(.DIV_N(DIV), .MOD_N(60),  .DEB_N(DEB)) u_dut60  (.clk(clk), .rst(rst), .bus(if60));
    bcd_modn_counter #(.DIV_N(DIV), .MOD_N(24),  .DEB_N(DEB)) u_dut24  (.clk(clk), .rst(rst), .bus(if24));
    bcd_modn_counter #(.DIV_N(DIV), .MOD_N(100), .DEB_N(DEB)) u_dut100 (.clk(clk), .rst(rst), .bus(if100));

    // ------------------------------------------------------------------
    // Reference model: count kept as a plain integer 0..MOD_N-1
    // ------------------------------------------------------------------
    int  mods [3] = '{60, 24, 100};
    int  m_cnt [3];
    bit  m_carry [3];
    int  m_pre   = 0;
    bit  m_run   = 1'b0;
    bit  m_level = 1'b1;
    bit  kq [$];
    bit  wq [$];

    logic [27:0] exp_q0 [$];
    logic [27:0] exp_q1 [$];
    logic [27:0] exp_q2 [$];

    function automatic logic [6:0] seg_ref(int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [27:0] pack_exp(bit r, int v, bit c);
        int t = v / 10;
        int u = v % 10;
        return {r, 4'(t), 4'(u), c, 2'b00, seg_ref(t), 2'b00, seg_ref(u)};
    endfunction

    task automatic model_step();
        bit seen;
        bit all_diff;
        bit old_run;
        bit tick;
        int lt;
        int lu;
        if (!rst) begin
            m_pre   = 0;
            m_run   = 1'b0;
            m_level = 1'b1;
            kq      = {1'b1, 1'b1};
            wq.delete();
            for (int k = 0; k < 3; k++) begin
                m_cnt[k]   = 0;
                m_carry[k] = 1'b0;
            end
        end else begin
            tick    = (m_pre == DIV - 1);
            m_pre   = tick ? 0 : m_pre + 1;
            old_run = m_run;
            // Key reaches the debouncer two clocks after it is sampled.
            seen = kq.pop_front();
            kq.push_back(key);
            wq.push_back(seen);
            if (wq.size() > DEB) void'(wq.pop_front());
            all_diff = (wq.size() == DEB);
            foreach (wq[i]) if (wq[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                if (m_level) m_run = !m_run;
                m_level = !m_level;
            end
            lt = int'(lval[7:4]);
            lu = int'(lval[3:0]);
            for (int k = 0; k < 3; k++) begin
                m_carry[k] = 1'b0;
                if (load) begin
                    m_cnt[k] = (lt <= 9 && lu <= 9 && lt * 10 + lu < mods[k]) ? lt * 10 + lu : 0;
                end else if (tick && old_run) begin
                    if (up) begin
                        m_carry[k] = (m_cnt[k] == mods[k] - 1);
                        m_cnt[k]   = (m_cnt[k] + 1) % mods[k];
                    end else begin
                        m_carry[k] = (m_cnt[k] == 0);
                        m_cnt[k]   = (m_cnt[k] + mods[k] - 1) % mods[k];
                    end
                end
            end
        end
        exp_q0.push_back(pack_exp(m_run, m_cnt[0], m_carry[0]));
        exp_q1.push_back(pack_exp(m_run, m_cnt[1], m_carry[1]));
        exp_q2.push_back(pack_exp(m_run, m_cnt[2], m_carry[2]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic check_one(string name, logic [27:0] act, int which);
        logic [27:0] exp;
        bit          empty;
        n_tests++;
        case (which)
            0:       empty = (exp_q0.size() == 0);
            1:       empty = (exp_q1.size() == 0);
            default: empty = (exp_q2.size() == 0);
        endcase
        if (empty) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued at t=%0t, actual {run,cnt,carry,seg1,seg2}=%h", name, $time, act);
        end else begin
            case (which)
                0:       exp = exp_q0.pop_front();
                1:       exp = exp_q1.pop_front();
                default: exp = exp_q2.pop_front();
            endcase
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s t=%0t: actual run=%b cnt=%h carry=%b seg1=%h seg2=%h, required run=%b cnt=%h carry=%b seg1=%h seg2=%h",
                         name, $time, act[27], act[26:19], act[18], act[17:9], act[8:0],
                         exp[27], exp[26:19], exp[18], exp[17:9], exp[8:0]);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_one("mod60",  {if60.run,  if60.cnt,  if60.carry,  if60.segment_led_1,  if60.segment_led_2},  0);
            check_one("mod24",  {if24.run,  if24.cnt,  if24.carry,  if24.segment_led_1,  if24.segment_led_2},  1);
            check_one("mod100", {if100.run, if100.cnt, if100.carry, if100.segment_led_1, if100.segment_led_2}, 2);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(int low);
        key = 1'b0;
        cyc(low);
        key = 1'b1;
    endtask

    task automatic do_load(logic [7:0] v);
        lval = v;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);

        // Clean press starts counting from 00.
        press(10);
        cyc(20);

        // Up wrap from 58.
        up = 1'b1;
        do_load(8'h58);
        cyc(14);

        // Down wrap from 01.
        up = 1'b0;
        do_load(8'h01);
        cyc(14);

        // Bouncing key must not toggle run.
        key = 1'b0; cyc(2);
        key = 1'b1; cyc(1);
        key = 1'b0; cyc(2);
        key = 1'b1; cyc(10);

        // Clean press pauses; count holds over several ticks.
        press(5);
        cyc(20);

        // Illegal load, then a load coinciding with a tick while running.
        do_load(8'h7A);
        cyc(3);
        press(5);
        cyc(8);
        while (m_pre != DIV - 1) cyc(1);
        do_load(8'h30);
        cyc(6);

        // Full up sweep and full down sweep.
        up = 1'b1;
        do_load(8'h00);
        cyc(24 * DIV + 8);
        up = 1'b0;
        do_load(8'h99);
        cyc(100 * DIV + 8);

        // Reset in mid-count abandons counting.
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(20);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) key = ~key;
            if ($urandom_range(0, 49) == 0) up = ~up;
            load = ($urandom_range(0, 29) == 0);
            lval = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                   {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rst  = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        load = 1'b0;
        rst  = 1'b1;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
